// File: rtl/systolic_operand_loader.sv
// Operand loader for the 2x2 systolic convolution core: collects 16 matrix and 9 filter
// bytes, releases the core's reset, times the compute window and flags done.
module systolic_operand_loader #(
  parameter int DATA_W         = 8,
  parameter int COMPUTE_CYCLES = 20
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic [DATA_W-1:0] i00, i01, i02, i03,
  output logic [DATA_W-1:0] i10, i11, i12, i13,
  output logic [DATA_W-1:0] i20, i21, i22, i23,
  output logic [DATA_W-1:0] i30, i31, i32, i33,
  output logic [DATA_W-1:0] f00, f01, f02,
  output logic [DATA_W-1:0] f10, f11, f12,
  output logic [DATA_W-1:0] f20, f21, f22,
  output logic              array_rst,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(COMPUTE_CYCLES - 1);
  localparam logic [4:0] IDX_LAST = 5'd24;

  state_t            state;
  logic [4:0]        idx;
  logic [7:0]        cnt;
  logic              done_q;
  logic [DATA_W-1:0] opr [25];
  logic              accept;

  // in_ready is decoded from state, so accept never feeds back into the handshake
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      idx    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 25; i++) opr[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state <= LOAD;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              opr[idx] <= in_data;
              if (idx == IDX_LAST) begin
                idx   <= '0;
                cnt   <= '0;
                state <= RUN;
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end
          RUN: begin
            cnt <= cnt + 8'd1;
            if (cnt == CNT_LAST) state <= DONE;
          end
          // done trails entry into DONE by one cycle to cover the core's result shift
          DONE:    done_q <= 1'b1;
          default: state  <= LOAD;
        endcase
      end
    end
  end

  assign in_ready  = (state == LOAD);
  assign array_rst = (state == LOAD);
  assign busy      = (state == RUN);
  assign done      = done_q;

  assign i00 = opr[0];  assign i01 = opr[1];  assign i02 = opr[2];  assign i03 = opr[3];
  assign i10 = opr[4];  assign i11 = opr[5];  assign i12 = opr[6];  assign i13 = opr[7];
  assign i20 = opr[8];  assign i21 = opr[9];  assign i22 = opr[10]; assign i23 = opr[11];
  assign i30 = opr[12]; assign i31 = opr[13]; assign i32 = opr[14]; assign i33 = opr[15];
  assign f00 = opr[16]; assign f01 = opr[17]; assign f02 = opr[18];
  assign f10 = opr[19]; assign f11 = opr[20]; assign f12 = opr[21];
  assign f20 = opr[22]; assign f21 = opr[23]; assign f22 = opr[24];

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Scoreboard bench for systolic_operand_loader: loads push expected operand sets and
// accept times; a monitor pops and checks them whenever done rises.
module tb_systolic_operand_loader;

  localparam int C = 20;

  logic       clk = 1'b0;
  logic       rst, in_valid, clear;
  logic [7:0] in_data;
  logic       in_ready, array_rst, busy, done;
  logic [7:0] op [25];

  typedef struct {
    logic [199:0] ops;
    int           acc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model [25];
  int         m_idx = 0;
  int         acc_cyc = 0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         busy_cnt = 0;
  logic       done_d = 1'b0;

  systolic_operand_loader #(.DATA_W(8), .COMPUTE_CYCLES(C)) dut (
    .clk_in(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear),
    .i00(op[0]),  .i01(op[1]),  .i02(op[2]),  .i03(op[3]),
    .i10(op[4]),  .i11(op[5]),  .i12(op[6]),  .i13(op[7]),
    .i20(op[8]),  .i21(op[9]),  .i22(op[10]), .i23(op[11]),
    .i30(op[12]), .i31(op[13]), .i32(op[14]), .i33(op[15]),
    .f00(op[16]), .f01(op[17]), .f02(op[18]),
    .f10(op[19]), .f11(op[20]), .f12(op[21]),
    .f20(op[22]), .f21(op[23]), .f22(op[24]),
    .array_rst(array_rst), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [199:0] pack_dut();
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = op[i];
    return v;
  endfunction

  function automatic logic [199:0] pack_model();
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = model[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops one expectation per rising edge of done
  always @(negedge clk) begin
    exp_t e;
    if (array_rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done && !done_d) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done_unexpected: got done=1 expected no pending result at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("done_latency", 200'(cyc - e.acc), 200'(C + 1));
        chk("busy_cycles", 200'(busy_cnt), 200'(C));
        chk("ops_at_done", pack_dut(), e.ops);
      end
    end
    done_d = done;
  end

  task automatic load_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model[m_idx] = b;
    if (m_idx == 24) begin
      m_idx   = 0;
      acc_cyc = cyc;
    end else begin
      m_idx++;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.ops = pack_model();
    e.acc = acc_cyc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_idx = 0;
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_timeout", 200'(seen), 200'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int lows;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 25; i++) model[i] = 8'h00;
    repeat (2) @(posedge clk); #1;

    chk("rst_in_ready", 200'(in_ready), 200'(1));
    chk("rst_array_rst", 200'(array_rst), 200'(1));
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    chk("rst_ops", pack_dut(), 200'(0));
    rst = 1'b0;
    idle(1);

    // Mapping: bytes 1..25 back to back
    for (int k = 1; k <= 25; k++) load_byte(8'(k));
    push_exp();
    chk("map_in_ready", 200'(in_ready), 200'(0));
    chk("map_array_rst", 200'(array_rst), 200'(0));
    chk("map_busy", 200'(busy), 200'(1));
    chk("map_i00", 200'(op[0]), 200'(1));
    chk("map_i03", 200'(op[3]), 200'(4));
    chk("map_i10", 200'(op[4]), 200'(5));
    chk("map_i33", 200'(op[15]), 200'(16));
    chk("map_f00", 200'(op[16]), 200'(17));
    chk("map_f22", 200'(op[24]), 200'(25));
    wait_done();

    // done holds while idle; bytes offered outside LOAD are ignored
    lows = 0;
    in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!done) lows++;
    end
    in_valid = 1'b0;
    chk("done_hold_low_cycles", 200'(lows), 200'(0));
    chk("done_in_ready", 200'(in_ready), 200'(0));
    chk("done_ops_stable", pack_dut(), pack_model());

    do_clear();
    chk("clr_array_rst", 200'(array_rst), 200'(1));
    chk("clr_in_ready", 200'(in_ready), 200'(1));
    chk("clr_done", 200'(done), 200'(0));
    chk("clr_busy", 200'(busy), 200'(0));

    // Gapped stream: valid pattern 1,0,0,1,...
    for (int k = 1; k <= 25; k++) begin
      load_byte(8'(k));
      if (k < 25) idle(2);
    end
    push_exp();
    chk("gap_ops", pack_dut(), pack_model());
    chk("gap_busy", 200'(busy), 200'(1));
    wait_done();

    // Clear mid-load with a simultaneous byte that must be dropped
    do_clear();
    for (int k = 0; k < 10; k++) load_byte(8'(50 + k));
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    m_idx = 0;
    chk("clrld_i22_kept", 200'(op[10]), 200'(11));
    chk("clrld_i00_kept", 200'(op[0]), 200'(50));
    chk("clrld_in_ready", 200'(in_ready), 200'(1));
    for (int k = 0; k < 25; k++) load_byte(8'd2);
    push_exp();
    chk("clrld_all_two", pack_dut(), {25{8'd2}});
    wait_done();

    // Asynchronous reset five cycles into RUN
    do_clear();
    for (int k = 1; k <= 25; k++) load_byte(8'(k));
    idle(5);
    chk("pre_rst_busy", 200'(busy), 200'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 200'(in_ready), 200'(1));
    chk("arst_array_rst", 200'(array_rst), 200'(1));
    chk("arst_busy", 200'(busy), 200'(0));
    chk("arst_done", 200'(done), 200'(0));
    chk("arst_ops", pack_dut(), 200'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(30);

    chk("scoreboard_empty", 200'(q.size()), 200'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
